uart_character_receiver: RTL
============================

// Module: uart_character_receiver
// PURPOSE
//  Asynchronous serial (8N1-style) receiver placed directly upstream of the
//  character_received PIO. Oversamples rx_serial with a per-bit counter and
//  deserialises frames LSB-first into data_out. Raises the character_received
//  level, which feeds the PIO in_port so software polls it over Avalon.
//  Software acknowledges through a separate strobe (ack), driven from an output PIO.
// PARAMETERS
//  CLKS_PER_BIT  5208  clk cycles per serial bit (50 MHz / 9600 baud); must be >= 4
//  DATA_BITS     8     data bits per frame (1..8); no parity; one stop bit
//  CNT_W         $clog2(CLKS_PER_BIT)  bit-counter width (localparam, derived)
// PORTS
//  clk                 in   1          system clock; single clock domain
//  reset_n             in   1          asynchronous, active-low reset
//  rx_serial           in   1          raw serial line, idle high, asynchronous to clk
//  ack                 in   1          one-cycle strobe: software consumed data_out
//  data_out            out  DATA_BITS  last good character, LSB = first bit received
//  character_received  out  1          level: unread character in data_out
//  framing_error       out  1          level: last frame had stop bit = 0
//  overrun             out  1          level: character overwritten before ack
// BEHAVIOUR
//  Reset (async, reset_n=0): state=IDLE, counters=0, data_out=0, all flags=0,
//   synchroniser flops=1 (line idle). Reset mid-frame abandons the frame silently.
//  rx_serial passes through a 2-flop synchroniser -> rx_sync (2-cycle latency).
//  FSM states: IDLE, START, DATA, STOP, BREAK.
//   IDLE : rx_sync==0 -> START, cnt=0.
//   START: cnt counts up; at cnt==CLKS_PER_BIT/2-1 re-check rx_sync:
//          0 -> DATA, cnt=0, bit_idx=0; 1 -> IDLE (glitch rejected, no flags).
//   DATA : at cnt==CLKS_PER_BIT-1 shift rx_sync into bit bit_idx, cnt=0;
//          after bit DATA_BITS-1 -> STOP. Sampling is thus mid-bit.
//   STOP : at cnt==CLKS_PER_BIT-1 sample rx_sync:
//          1 -> data_out<=shift reg, character_received<=1, framing_error<=0, -> IDLE;
//          0 -> framing_error<=1, data_out and character_received unchanged, -> BREAK.
//   BREAK: wait for rx_sync==1, then -> IDLE (held-low line never retriggers).
//  Flag updates are registered: visible the cycle after the STOP sample edge.
//  ack (any state): clears character_received, overrun and framing_error next cycle.
//  Good frame completes while character_received==1 and no ack that cycle:
//   data_out overwritten with new char, overrun<=1.
//  Good frame completes in the same cycle as ack: new char wins;
//   character_received stays 1, overrun stays 0.
//  ack with character_received==0: no effect beyond clearing the error flags.
//  Counter never wraps: cnt resets on every state transition and bit sample.
// STRUCTURE
//  Package uart_rx_pkg: state enum type (IDLE, START, DATA, STOP, BREAK),
//   default CLKS_PER_BIT/DATA_BITS constants, and the helper function
//   half_bit(clks) = clks/2-1.
//  One sub-module: rx_bit_synchronizer (2-flop, reset value 1, async reset_n).
//  Remaining logic (FSM, cnt, bit_idx, shift reg, flags) stays flat in this module.
// TESTING  (bench uses CLKS_PER_BIT=16, DATA_BITS=8)
//  1. Send 0x41 (start 0, bits 1,0,0,0,0,0,1,0, stop 1), no ack -> data_out=0x41,
//     character_received=1, framing_error=0, overrun=0 until ack;
//     one-cycle ack -> character_received=0 next cycle.
//  2. Send 0x55, then 0xAA without ack -> data_out=0xAA, character_received=1, overrun=1;
//     ack -> overrun=0 and character_received=0.
//  3. Send 0x3C with stop bit driven 0, line held low 40 cycles -> framing_error=1,
//     data_out keeps its prior value, no new start detected until line returns high.
//  4. 5-cycle low glitch on an idle line -> FSM returns to IDLE, no flags set;
//     then a valid 0x7E -> received correctly.
//  5. Assert ack in the exact cycle a 0x12 frame completes while flag=1 ->
//     data_out=0x12, character_received=1, overrun=0.
//  6. Assert reset_n=0 mid-DATA of 0xFF, release, then send 0x81 ->
//     all outputs 0 during reset; only 0x81 is reported afterwards.

Source files
------------

// File: rtl/uart_character_receiver_pkg.sv
// Shared types and constants for the UART character receiver.
// Holds the receiver FSM state type, default frame timing, and the half-bit helper.
package uart_rx_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 5208;
    localparam int DEFAULT_DATA_BITS    = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } rx_state_e;

    // Counter value at which the start bit is re-checked, i.e. the middle of the bit.
    function automatic int half_bit(input int clks);
        return clks / 2 - 1;
    endfunction

endpackage

// File: rtl/uart_character_receiver_if.sv
// Serial-line and character-status bundle between the receiver and its PIO side.
// The slave modport is the receiver; the master modport is the line driver and software side.
interface uart_character_receiver_if
    import uart_rx_pkg::*;
#(
    parameter int DATA_BITS = DEFAULT_DATA_BITS
);

    logic                 rx_serial;
    logic                 ack;
    logic [DATA_BITS-1:0] data_out;
    logic                 character_received;
    logic                 framing_error;
    logic                 overrun;

    modport master (
        output rx_serial,
        output ack,
        input  data_out,
        input  character_received,
        input  framing_error,
        input  overrun
    );

    modport slave (
        input  rx_serial,
        input  ack,
        output data_out,
        output character_received,
        output framing_error,
        output overrun
    );

endinterface

// File: rtl/uart_character_receiver_sync.sv
// Two-flop synchroniser for the asynchronous serial line.
// Resets to 1 so that a reset is seen as an idle line, never as a start bit.
module rx_bit_synchronizer (
    input  logic clk,
    input  logic reset_n,
    input  logic async_in,
    output logic sync_out
);

    logic meta_q;
    logic sync_q;

    // NOTE: sequential state uses <= so both flops sample the pre-edge values and form a real 2-stage chain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= async_in;
            sync_q <= meta_q;
        end
    end

    assign sync_out = sync_q;

endmodule

// File: rtl/uart_character_receiver.sv
// 8N1-style asynchronous serial receiver feeding a polled character_received PIO.
// Frames are sampled mid-bit, deserialised LSB-first, and held until software acks.
module uart_character_receiver
    import uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int DATA_BITS    = DEFAULT_DATA_BITS
) (
    input logic                      clk,
    input logic                      reset_n,
    uart_character_receiver_if.slave rx_if
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(half_bit(CLKS_PER_BIT));
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    rx_state_e            state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [IDX_W-1:0]     bit_idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] data_q;
    logic                 char_q;
    logic                 frame_err_q;
    logic                 overrun_q;

    logic rx_sync;
    logic stop_sample;
    logic frame_good;
    logic frame_bad;

    rx_bit_synchronizer u_sync (
        .clk      (clk),
        .reset_n  (reset_n),
        .async_in (rx_if.rx_serial),
        .sync_out (rx_sync)
    );

    assign stop_sample = (state_q == ST_STOP) && (cnt_q == CNT_LAST);
    assign frame_good  = stop_sample &&  rx_sync;
    assign frame_bad   = stop_sample && !rx_sync;

    // Frame sequencing: cnt restarts on every transition and every bit sample.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!rx_sync) begin
                        state_q <= ST_START;
                        cnt_q   <= '0;
                    end
                end
                ST_START: begin
                    if (cnt_q == CNT_HALF) begin
                        cnt_q     <= '0;
                        bit_idx_q <= '0;
                        state_q   <= rx_sync ? ST_IDLE : ST_DATA;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q              <= '0;
                        shift_q[bit_idx_q] <= rx_sync;
                        if (bit_idx_q == IDX_LAST) begin
                            state_q <= ST_STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q   <= '0;
                        state_q <= rx_sync ? ST_IDLE : ST_BREAK;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_BREAK: begin
                    // A held-low line must return high before a new start bit is accepted.
                    if (rx_sync) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // Status flags; a completing frame takes priority over a same-cycle ack.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q      <= '0;
            char_q      <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else if (frame_good) begin
            data_q      <= shift_q;
            char_q      <= 1'b1;
            frame_err_q <= 1'b0;
            overrun_q   <= rx_if.ack ? 1'b0 : (overrun_q | char_q);
        end else if (frame_bad) begin
            frame_err_q <= 1'b1;
            if (rx_if.ack) begin
                char_q    <= 1'b0;
                overrun_q <= 1'b0;
            end
        end else if (rx_if.ack) begin
            char_q      <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end
    end

    assign rx_if.data_out           = data_q;
    assign rx_if.character_received = char_q;
    assign rx_if.framing_error      = frame_err_q;
    assign rx_if.overrun            = overrun_q;

endmodule
